// File: rtl/mgc_in_fifo_wait_edge_if.sv
// Wait-handshake channel bundle: environment push side (vz/z/lz) and design pop side (ld/vd/d/size).
// The FIFO takes the slave view; whoever drives pushes and pops takes the master view.
interface mgc_in_fifo_wait_edge_if #(
  parameter int width   = 8,
  parameter int ph_log2 = 3
);
  logic               vz;
  logic [width-1:0]   z;
  logic               lz;
  logic               ld;
  logic               vd;
  logic [width-1:0]   d;
  logic [ph_log2:0]   size;

  modport master (output vz, z, ld, input lz, vd, d, size);
  modport slave  (input vz, z, ld, output lz, vd, d, size);
endinterface

// File: rtl/mgc_in_fifo_wait_edge.sv
// Receiving-end FIFO of the wait handshake: first-word-fall-through, push visible on d one edge later.
// Backpressure: lz drops when full or disabled; a full FIFO refuses a push even when popped that cycle.
module mgc_in_fifo_wait_edge #(
  parameter int rscid   = 0,
  parameter int width   = 8,
  parameter int fifo_sz = 8,
  parameter int ph_log2 = 3
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 en,
  mgc_in_fifo_wait_edge_if.slave io
);

  if (rscid < 0 || fifo_sz < 1 || ph_log2 < 1 || fifo_sz > (1 << ph_log2)) begin : g_param_check
    $error("mgc_in_fifo_wait_edge: illegal parameter combination");
  end

  localparam logic [ph_log2-1:0] LAST = ph_log2'(fifo_sz - 1);
  localparam logic [ph_log2:0]   FULL = (ph_log2 + 1)'(fifo_sz);

  logic [width-1:0]   mem [fifo_sz];
  logic [ph_log2-1:0] wr_ptr;
  logic [ph_log2-1:0] rd_ptr;
  logic [ph_log2:0]   count;
  logic               push;
  logic               pop;

  // Ready/valid come only from registered count, so neither side sees the other combinationally.
  assign io.lz   = en & (count != FULL);
  assign io.vd   = en & (count != '0);
  assign io.size = count;
  assign io.d    = mem[rd_ptr];

  assign push = io.vz & io.lz;
  assign pop  = io.ld & io.vd;

  // Storage is not reset; a write landing during reset is invisible because count is held at 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= io.z;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
